binary_downscale_filter: RTL



---
 rtl/binary_downscale_filter_pkg.sv | 18 +
 rtl/binary_downscale_filter_if.sv | 49 ++++
 rtl/binary_downscale_filter_popcount8.sv | 15 +
 rtl/binary_downscale_filter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/binary_downscale_filter_pkg.sv
// Shared constants and types for the nonogram image path.
// Image geometry matches the stored camera photo. The downscaled grid is
// one bit per GRID_BLK x GRID_BLK block.
package nonogram_pkg;

  localparam int IMG_W    = 320;
  localparam int IMG_H    = 240;
  localparam int GRID_BLK = 8;
  localparam int GRID_W   = IMG_W / GRID_BLK;
  localparam int GRID_H   = IMG_H / GRID_BLK;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } bds_state_t;

endpackage

// File: rtl/binary_downscale_filter_if.sv
// Row-stream bundle between the thresholding path, the downscaler and the
// constraint-generator storage.
// The optional black_blocks_out statistic exists only when BDS_STATS_EN is
// defined.
interface binary_downscale_filter_if import nonogram_pkg::*; #(
  parameter int IN_W = IMG_W,
  parameter int IN_H = IMG_H,
  parameter int BLK  = GRID_BLK
);

  localparam int OUT_W  = IN_W / BLK;
  localparam int IDX_W  = $clog2(IN_H / BLK);
  localparam int STAT_W = $clog2(IN_W * IN_H / BLK / BLK + 1);

  logic              start_in;
  logic              row_valid_in;
  logic [IN_W-1:0]   row_in;
  logic              row_valid_out;
  logic [OUT_W-1:0]  row_out;
  logic [IDX_W-1:0]  row_idx_out;
  logic              busy_out;
  logic              done_out;
`ifdef BDS_STATS_EN
  logic [STAT_W-1:0] black_blocks_out;

  modport master (
    output start_in, row_valid_in, row_in,
    input  row_valid_out, row_out, row_idx_out, busy_out, done_out,
           black_blocks_out
  );

  modport slave (
    input  start_in, row_valid_in, row_in,
    output row_valid_out, row_out, row_idx_out, busy_out, done_out,
           black_blocks_out
  );
`else
  modport master (
    output start_in, row_valid_in, row_in,
    input  row_valid_out, row_out, row_idx_out, busy_out, done_out
  );

  modport slave (
    input  start_in, row_valid_in, row_in,
    output row_valid_out, row_out, row_idx_out, busy_out, done_out
  );
`endif

endinterface

// File: rtl/binary_downscale_filter_popcount8.sv
// Combinational population count of one 8-pixel block slice.
module popcount8 (
  input  logic [7:0] i_bits,
  output logic [3:0] o_count
);

  // Sum the eight pixel bits.
  always_comb begin
    o_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      o_count = o_count + {3'b000, i_bits[i]};
    end
  end

endmodule

// File: rtl/binary_downscale_filter.sv
// Streaming 8x8 majority box filter: one 320-pixel binary row in per
// accepted cycle, one 40-bit row out per band of BLK accepted rows, and a
// done pulse after the last band.
// Optional feature macro: BDS_STATS_EN adds a per-frame count of set
// output bits (black_blocks_out).
module binary_downscale_filter import nonogram_pkg::*; #(
  parameter int IN_W   = IMG_W,
  parameter int IN_H   = IMG_H,
  parameter int BLK    = GRID_BLK,
  parameter int THRESH = 32
) (
  input  logic clk_in,
  input  logic reset_in,
  binary_downscale_filter_if.slave bus
);

  localparam int NB     = IN_W / BLK;
  localparam int NBANDS = IN_H / BLK;
  localparam int IDX_W  = $clog2(NBANDS);
  localparam int BAND_W = $clog2(BLK);
  localparam int CNT_W  = $clog2(BLK * BLK + 1);
  localparam int STAT_W = $clog2(IN_W * IN_H / BLK / BLK + 1);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_ACCUM = 2'(ACCUM);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  logic [1:0]        r_state;
  logic [BAND_W-1:0] r_band_row;
  logic [IDX_W-1:0]  r_out_row;
  logic              r_busy;
  logic              r_done;
  logic              r_valid;
  logic [NB-1:0]     r_row_out;
  logic [IDX_W-1:0]  r_row_idx;
  logic [CNT_W-1:0]  r_cnt [NB];

  logic [3:0]        w_pc [NB];
  logic [CNT_W-1:0]  w_sum [NB];
  logic [NB-1:0]     w_bits;
  logic              w_accept;
  logic              w_band_end;
  logic              w_last_band;

  // One popcount per block column of the incoming row.
  for (genvar k = 0; k < NB; k++) begin : g_pc
    popcount8 u_pc (
      .i_bits  (bus.row_in[k*BLK +: 8]),
      .o_count (w_pc[k])
    );
  end

  // A row counts only while accumulating and not being overridden by start.
  always_comb begin
    w_accept    = (r_state == ST_ACCUM) && bus.row_valid_in && !bus.start_in;
    w_band_end  = w_accept && (r_band_row == BAND_W'(BLK - 1));
    w_last_band = (r_out_row == IDX_W'(NBANDS - 1));
  end

  // Block totals including the current row, and their majority decision.
  always_comb begin
    for (int k = 0; k < NB; k++) begin
      w_sum[k]  = r_cnt[k] + {{(CNT_W-4){1'b0}}, w_pc[k]};
      w_bits[k] = (w_sum[k] >= CNT_W'(THRESH));
    end
  end

  // Frame sequencing, output row register and status pulses.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state    <= ST_IDLE;
      r_band_row <= '0;
      r_out_row  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_row_out  <= '0;
      r_row_idx  <= '0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (bus.start_in) begin
        // start in any state (re)opens a frame; an aborted frame gets no done
        r_state    <= ST_ACCUM;
        r_band_row <= '0;
        r_out_row  <= '0;
        r_busy     <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_ACCUM: begin
            if (w_band_end) begin
              r_band_row <= '0;
              r_valid    <= 1'b1;
              r_row_out  <= w_bits;
              r_row_idx  <= r_out_row;
              if (w_last_band) begin
                r_out_row <= '0;
                r_state   <= ST_DONE;
              end else begin
                r_out_row <= r_out_row + IDX_W'(1);
              end
            end else if (w_accept) begin
              r_band_row <= r_band_row + BAND_W'(1);
            end
          end
          ST_DONE: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Per-block black-pixel counters; zeroed on start and at each band end.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int k = 0; k < NB; k++) r_cnt[k] <= '0;
    end else if (bus.start_in || w_band_end) begin
      for (int k = 0; k < NB; k++) r_cnt[k] <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < NB; k++) r_cnt[k] <= w_sum[k];
    end
  end

  assign bus.row_valid_out = r_valid;
  assign bus.row_out       = r_row_out;
  assign bus.row_idx_out   = r_row_idx;
  assign bus.busy_out      = r_busy;
  assign bus.done_out      = r_done;

`ifdef BDS_STATS_EN
  logic [STAT_W-1:0] r_black_blocks;
  logic [STAT_W-1:0] w_band_ones;

  // Number of set bits in the row about to be emitted.
  always_comb begin
    w_band_ones = '0;
    for (int k = 0; k < NB; k++) begin
      w_band_ones = w_band_ones + STAT_W'(w_bits[k]);
    end
  end

  // Running frame total of set output bits.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_black_blocks <= '0;
    end else if (bus.start_in) begin
      r_black_blocks <= '0;
    end else if (w_band_end) begin
      r_black_blocks <= r_black_blocks + w_band_ones;
    end
  end

  assign bus.black_blocks_out = r_black_blocks;
`endif

endmodule
